regfile_wb_scheduler: RTL
=========================

REGFILE_WB_SCHEDULER -- requirements
Module: regfile_wb_scheduler

Interface
Parameters:
REQ-001 SHALL have parameter RR_EN, default 1, meaning 1 = round-robin arbitration and 0 = fixed priority to requester A.
Ports:
REQ-002 SHALL have port clk_i  input  1  single clock; all state changes on its rising edge.
REQ-003 SHALL have port rst_i  input  1  reset, asynchronous and active-low.
REQ-004 SHALL have port issue_valid_i  input  1  instruction issuing that will write issue_rd_i.
REQ-005 SHALL have port issue_rd_i  input  5  destination register of the issuing instruction.
REQ-006 SHALL have port issue_ready_o  output  1  issue accepted this cycle.
REQ-007 SHALL have ports rs1_sel_i and rs2_sel_i  input  5 each  source registers of the instruction in decode.
REQ-008 SHALL have port stall_o  output  1  a decode source has a pending write.
REQ-009 SHALL have ports a_valid_i  input  1, a_rd_i  input  5, a_data_i  input  32 and a_ready_o  output  1, forming write-back requester A (ALU).
REQ-010 SHALL have ports b_valid_i  input  1, b_rd_i  input  5, b_data_i  input  32 and b_ready_o  output  1, forming write-back requester B (load unit).
REQ-011 SHALL have port selRd_o  output  5  register-file write select; 0 = no write.
REQ-012 SHALL have port rd_o  output  32  register-file write data.
REQ-013 SHALL have port busy_cnt_o  output  6  number of registers with a pending write, range 0..31.

Function
REQ-014 SHALL keep a 32-entry busy vector with bit 0 hardwired to 0.
REQ-015 SHALL drive issue_ready_o combinationally: 1 when issue_rd_i==0 or busy[issue_rd_i]==0, otherwise 0.
REQ-016 SHALL, on an edge with issue_valid_i & issue_ready_o and issue_rd_i!=0, set busy[issue_rd_i].
REQ-017 SHALL drive stall_o combinationally as (rs1_sel_i!=0 & busy[rs1_sel_i]) | (rs2_sel_i!=0 & busy[rs2_sel_i]), with no bypass from a same-cycle issue or clear.
REQ-018 SHALL grant at most one requester per cycle; a_ready_o and b_ready_o are combinational grants, mutually exclusive, and never asserted without the matching valid.
REQ-019 SHALL grant the single valid requester when only one of them is valid.
REQ-020 SHALL, with both valid and RR_EN=1, grant the requester not granted last; the last-grant pointer updates only on a completed grant.
REQ-021 SHALL, with both valid and RR_EN=0, always grant A.
REQ-022 SHALL define a transfer as valid & ready on a clock edge; requesters hold rd and data stable until ready.
REQ-023 SHALL register each transfer into the output stage: on transfer edge N, selRd_o and rd_o take the granted rd and data.
REQ-024 SHALL set selRd_o=0 and hold rd_o at its previous value on any edge without a transfer, so every write is a single-cycle pulse.
REQ-025 SHALL clear busy[selRd_o] on edge N+1, the edge where the register file captures the write.
REQ-026 SHALL make the written register readable without stall from cycle N+1 onward.
REQ-027 SHALL treat a transfer with rd==0 as consumed, with selRd_o=0 and no busy change.
REQ-028 SHALL treat a clear of a non-busy register as a no-op.
REQ-029 SHALL clear a different register when a set and a clear occur on the same edge; the same register cannot coincide under REQ-015.
REQ-030 SHALL apply set and clear of different registers on the same edge together, with busy_cnt_o updated by +1, -1 or 0 accordingly.
REQ-031 SHALL register busy_cnt_o, consistent with the busy vector every cycle.

Reset
REQ-032 SHALL, while rst_i=0 and asynchronously: clear all busy bits; set busy_cnt_o=0, selRd_o=0, rd_o=0; set the round-robin pointer so that A is granted first.
REQ-033 SHALL drop writes in flight at reset assertion, with no write emitted after reset release.
REQ-034 SHALL allow issue_ready_o, stall_o and grants to follow inputs combinationally during reset, with no state change until release.

Verification
REQ-035 SHALL cover: issue rd=5, then A writes rd=5 data 0xDEADBEEF -> stall_o for rs1=5 high until edge N+1, selRd_o=5 and rd_o=0xDEADBEEF for exactly one cycle, busy_cnt_o 1->0.
REQ-036 SHALL cover: A and B valid continuously with RR_EN=1 -> grants A,B,A,B; with RR_EN=0 -> A every cycle and B only after A drops.
REQ-037 SHALL cover: issue rd=7 while busy[7]=1 -> issue_ready_o=0 and busy_cnt_o unchanged; after the write of 7 completes -> issue_ready_o=1.
REQ-038 SHALL cover: B writes rd=0 data 0x12345678 -> b_ready_o=1, selRd_o stays 0, busy_cnt_o unchanged.
REQ-039 SHALL cover: issue rd=3 and clear of rd=9 on the same edge -> busy[3]=1, busy[9]=0, busy_cnt_o unchanged.
REQ-040 SHALL cover: rst_i asserted mid-cycle with 4 busy registers and a write pending -> busy_cnt_o=0 and selRd_o=0 immediately, stall_o=0, and no write after release.

Source files
------------

// File: rtl/regfile_wb_scheduler.sv
// ---------------------------------------------------------------------------
// regfile_wb_scheduler
//
// Tracks which architectural registers have a write outstanding (scoreboard),
// stalls decode on hazards, and arbitrates two write-back requesters onto a
// single register-file write port.
//
// Ports
//   clk_i, rst_i            : clock, asynchronous active-low reset
//   issue_valid_i/rd_i      : instruction issuing with destination rd
//   issue_ready_o           : destination is free, issue accepted
//   rs1_sel_i, rs2_sel_i    : decode source registers
//   stall_o                 : a decode source has a pending write
//   a_* / b_*               : write-back requesters A (ALU) and B (load)
//   selRd_o, rd_o           : registered write select (0 = none) and data
//   busy_cnt_o              : number of registers with a pending write
//
// Parameter
//   RR_EN                   : 1 = round-robin between A and B, 0 = A first
// ---------------------------------------------------------------------------
module regfile_wb_scheduler #(
  parameter bit RR_EN = 1'b1
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        issue_valid_i,
  input  logic [4:0]  issue_rd_i,
  output logic        issue_ready_o,
  input  logic [4:0]  rs1_sel_i,
  input  logic [4:0]  rs2_sel_i,
  output logic        stall_o,
  input  logic        a_valid_i,
  input  logic [4:0]  a_rd_i,
  input  logic [31:0] a_data_i,
  output logic        a_ready_o,
  input  logic        b_valid_i,
  input  logic [4:0]  b_rd_i,
  input  logic [31:0] b_data_i,
  output logic        b_ready_o,
  output logic [4:0]  selRd_o,
  output logic [31:0] rd_o,
  output logic [5:0]  busy_cnt_o
);

  // Which requester won the most recent completed grant.
  typedef enum logic {
    LAST_A = 1'b0,
    LAST_B = 1'b1
  } last_e;

  logic [31:0] busy_q, busy_d;
  logic [5:0]  busy_cnt_q, busy_cnt_d;
  logic [4:0]  sel_rd_q, sel_rd_d;
  logic [31:0] rd_data_q, rd_data_d;
  last_e       last_q, last_d;

  logic        xfer;
  logic [4:0]  xfer_rd;
  logic [31:0] xfer_data;
  logic        set_en;
  logic        clr_en;

  // Scoreboard lookups; no bypass from same-cycle set/clear.
  assign issue_ready_o = (issue_rd_i == 5'd0) || !busy_q[issue_rd_i];
  assign stall_o       = ((rs1_sel_i != 5'd0) && busy_q[rs1_sel_i]) ||
                         ((rs2_sel_i != 5'd0) && busy_q[rs2_sel_i]);

  // Grants are combinational and only ever asserted alongside their valid.
  always_comb begin
    // NOTE: every output of a combinational block gets a default first so no
    // path through the block leaves it unassigned (which would infer a latch).
    a_ready_o = 1'b0;
    b_ready_o = 1'b0;
    if (a_valid_i && b_valid_i) begin
      if (RR_EN && (last_q == LAST_A)) b_ready_o = 1'b1;
      else                             a_ready_o = 1'b1;
    end else if (a_valid_i) begin
      a_ready_o = 1'b1;
    end else if (b_valid_i) begin
      b_ready_o = 1'b1;
    end
  end

  assign xfer      = a_ready_o || b_ready_o;
  assign xfer_rd   = a_ready_o ? a_rd_i   : b_rd_i;
  assign xfer_data = a_ready_o ? a_data_i : b_data_i;

  // A set needs busy==0 and a real clear needs busy==1, so the two can never
  // hit the same register on one edge.
  assign set_en = issue_valid_i && issue_ready_o && (issue_rd_i != 5'd0);
  assign clr_en = (sel_rd_q != 5'd0) && busy_q[sel_rd_q];

  always_comb begin
    busy_d     = busy_q;
    busy_cnt_d = busy_cnt_q;
    sel_rd_d   = 5'd0;
    rd_data_d  = rd_data_q;
    last_d     = last_q;

    // Output stage: a write lives in selRd_o for exactly one cycle; the data
    // register holds its value between writes.
    if (xfer) begin
      sel_rd_d  = xfer_rd;
      rd_data_d = xfer_data;
    end

    if (a_ready_o)      last_d = LAST_A;
    else if (b_ready_o) last_d = LAST_B;

    // The clear lands on the edge the register file captures selRd_o.
    if (clr_en) busy_d[sel_rd_q]   = 1'b0;
    if (set_en) busy_d[issue_rd_i] = 1'b1;
    busy_d[0] = 1'b0;

    unique case ({set_en, clr_en})
      2'b10:   busy_cnt_d = busy_cnt_q + 6'd1;
      2'b01:   busy_cnt_d = busy_cnt_q - 6'd1;
      default: busy_cnt_d = busy_cnt_q;
    endcase
  end

  // Reset leaves last_q at LAST_B so the first contested grant goes to A, and
  // clears selRd so nothing in flight is written after release.
  always_ff @(posedge clk_i or negedge rst_i) begin
    if (!rst_i) begin
      // NOTE: every flop here is small control/datapath state, so all of it is
      // reset; a large storage array would normally be left unreset.
      busy_q     <= '0;
      busy_cnt_q <= '0;
      sel_rd_q   <= '0;
      rd_data_q  <= '0;
      last_q     <= LAST_B;
    end else begin
      // NOTE: sequential state uses non-blocking assignments so every flop
      // samples the pre-edge values regardless of statement order.
      busy_q     <= busy_d;
      busy_cnt_q <= busy_cnt_d;
      sel_rd_q   <= sel_rd_d;
      rd_data_q  <= rd_data_d;
      last_q     <= last_d;
    end
  end

  assign selRd_o    = sel_rd_q;
  assign rd_o       = rd_data_q;
  assign busy_cnt_o = busy_cnt_q;

endmodule
